// File: rtl/local_memory_arbiter_pkg.sv
// Shared constants, port encodings and arbitration helpers for the local
// memory arbiter; plays the role of global.h for this block.
package local_memory_arbiter_pkg;

  localparam int unsigned LMEM_W_WIDTH = 16;
  localparam int unsigned LMEM_W_ADDR  = 8;
  localparam int unsigned LMEM_RD_LAT  = 1;
  localparam int unsigned BURST_CNT_W  = 3;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } rd_tag_t;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

  // One round-robin decision: a lone requester wins, a tie goes away from last.
  function automatic port_e rr_pick(input logic a_req, input logic b_req,
                                    input port_e last);
    if (a_req && b_req) return other_port(last);
    if (a_req) return PORT_A;
    return PORT_B;
  endfunction

endpackage

// File: rtl/local_memory_arbiter_rd_tag_pipe.sv
// lmem_rd_tag_pipe: {valid, port} shift register that tracks reads in flight
// so each memory word is steered back to the requester that issued it.
module lmem_rd_tag_pipe
  import local_memory_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    clr_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/local_memory_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the split local memory.
// Optional feature: define LMEM_ARB_BURST_EN for owner bursts of up to MAX_BURST beats.
module local_memory_arbiter
  import local_memory_arbiter_pkg::*;
#(
  parameter int unsigned W_WIDTH   = LMEM_W_WIDTH,
  parameter int unsigned W_ADDR    = LMEM_W_ADDR,
  parameter int unsigned RD_LAT    = LMEM_RD_LAT,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               MCLK,
  input  logic               RST,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [W_ADDR-1:0]  a_addr,
  input  logic [W_WIDTH-1:0] a_wdata,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [W_WIDTH-1:0] a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [W_ADDR-1:0]  b_addr,
  input  logic [W_WIDTH-1:0] b_wdata,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic [W_WIDTH-1:0] b_rdata,
  output logic [W_WIDTH-1:0] mem_data,
  output logic [W_ADDR-1:0]  mem_wraddress,
  output logic [W_ADDR-1:0]  mem_rdaddress,
  output logic               mem_wren,
  input  logic [W_WIDTH-1:0] mem_q
);

  port_e              last_q, last_d;
  port_e              winner;
  logic               accept;
  logic               sel_we;
  logic [W_ADDR-1:0]  sel_addr;
  logic [W_WIDTH-1:0] sel_wdata;

  logic               wren_q, wren_d;
  logic [W_ADDR-1:0]  wraddr_q, wraddr_d;
  logic [W_ADDR-1:0]  rdaddr_q, rdaddr_d;
  logic [W_WIDTH-1:0] wdata_q, wdata_d;

  rd_tag_t            tag_in, tag_out;
  logic               a_hit, b_hit;
  logic [W_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [W_WIDTH-1:0] b_rdata_q, b_rdata_d;

  assign accept = (a_req || b_req) && !RST;

`ifdef LMEM_ARB_BURST_EN
  localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(MAX_BURST);

  logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
  logic                   owner_hold;

  // A zero count means no current owner, so the plain round-robin rule applies.
  always_comb begin
    owner_hold = (cnt_q != '0) && (cnt_q < BURST_LIM);
    winner     = (a_req && b_req && owner_hold) ? last_q
                                                : rr_pick(a_req, b_req, last_q);
  end

  always_comb begin
    cnt_d = '0;
    if (accept) begin
      if (winner != last_q) begin
        cnt_d = BURST_CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + BURST_CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign winner = rr_pick(a_req, b_req, last_q);
`endif

  assign a_gnt = accept && (winner == PORT_A);
  assign b_gnt = accept && (winner == PORT_B);

  always_comb begin
    sel_we    = b_we;
    sel_addr  = b_addr;
    sel_wdata = b_wdata;
    if (winner == PORT_A) begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
    end
  end

  // Address/data registers only move on the kind of access that uses them.
  always_comb begin
    last_d   = last_q;
    wren_d   = 1'b0;
    wraddr_d = wraddr_q;
    wdata_d  = wdata_q;
    rdaddr_d = rdaddr_q;
    if (accept) begin
      last_d = winner;
      if (sel_we) begin
        wren_d   = 1'b1;
        wraddr_d = sel_addr;
        wdata_d  = sel_wdata;
      end else begin
        rdaddr_d = sel_addr;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      last_q   <= PORT_B;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wdata_q  <= '0;
      rdaddr_q <= '0;
    end else begin
      last_q   <= last_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wdata_q  <= wdata_d;
      rdaddr_q <= rdaddr_d;
    end
  end

  assign mem_wren      = wren_q;
  assign mem_wraddress = wraddr_q;
  assign mem_data      = wdata_q;
  assign mem_rdaddress = rdaddr_q;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept && !sel_we;
    tag_in.port  = winner;
  end

  lmem_rd_tag_pipe #(
    .DEPTH (1 + RD_LAT)
  ) u_tag_pipe (
    .clk_i (MCLK),
    .clr_i (RST),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // mem_q is passed straight through on the tagged cycle and remembered for later.
  assign a_hit     = tag_out.valid && (tag_out.port == PORT_A) && !RST;
  assign b_hit     = tag_out.valid && (tag_out.port == PORT_B) && !RST;
  assign a_rdata_d = a_hit ? mem_q : a_rdata_q;
  assign b_rdata_d = b_hit ? mem_q : b_rdata_q;

  always_ff @(posedge MCLK) begin
    if (RST) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rvalid = a_hit;
  assign b_rvalid = b_hit;
  assign a_rdata  = a_rdata_d;
  assign b_rdata  = b_rdata_d;

endmodule

// File: doc/local_memory_arbiter.md
# local_memory_arbiter

Two-requester arbiter and sequencer for the split high/low local memory. Accepts word read/write requests from port A (host/config side) and port B (processing engine), grants at most one memory operation per cycle using round-robin arbitration, drives the memory's write and read ports from registered signals, and returns read data to the issuing requester with a fixed latency. Sits between the requesters and the `local_memory` instance, on the `MCLK` domain.

## Interface
- `W_WIDTH`, from `global.h`: memory word width.
- `W_ADDR`, from `global.h`: memory address width.
- `RD_LAT`, default 1: memory read latency in cycles, counted from `mem_rdaddress` to valid `mem_q`. Range 1–3.
- `MAX_BURST`, default 4: maximum number of consecutive beats granted to one owner. Used only with `LMEM_ARB_BURST_EN`.

Ports:
- `MCLK` in 1: the single clock.
- `RST` in 1: synchronous, active-high reset.
- `a_req` in 1: port A request, held until granted.
- `a_we` in 1: 1 = write, 0 = read.
- `a_addr` in `W_ADDR`: port A address.
- `a_wdata` in `W_WIDTH`: port A write data.
- `a_gnt` out 1: port A request accepted this cycle.
- `a_rvalid` out 1: port A read data valid.
- `a_rdata` out `W_WIDTH`: port A read data.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as port A, for port B.
- `mem_data` out `W_WIDTH`: memory write data.
- `mem_wraddress` out `W_ADDR`: memory write address.
- `mem_rdaddress` out `W_ADDR`: memory read address.
- `mem_wren` out 1: memory write enable.
- `mem_q` in `W_WIDTH`: full memory read word, high and low halves concatenated.

## Operation
- A transfer happens on a cycle where `x_req && x_gnt`.
- Requesters hold `req`, `we`, `addr` and `wdata` stable until granted.
- `a_gnt` and `b_gnt` are combinational from the request inputs and the arbiter state. They are never both high in the same cycle.
- Round-robin rule:
  - One pointer bit `last` records the last granted port.
  - If only one port requests, that port is granted.
  - If both request, the port other than `last` is granted.
  - `last` resets to B, so A wins the first tie.
- Accepted write: the next cycle has `mem_wren`=1, with `mem_wraddress` and `mem_data` taken from the accepted request.
- Accepted read: the next cycle presents `mem_rdaddress`. `mem_wren` is 0 on that cycle.
- Read return:
  - A tag shift register of depth 1+`RD_LAT` carries {valid, port}.
  - At the output stage, `x_rdata` = `mem_q` and `x_rvalid` pulses for one cycle on the tagged port.
  - `x_rdata` holds its last value when `x_rvalid` is low.
- Ordering: per-port responses return in issue order.
- Read after write to the same address, issued the cycle after the write, returns the new data. The write completes at the edge before the read address is applied.
- When no request is accepted, `mem_wren`=0 and the memory address outputs hold their previous values.
- Reset:
  - All outputs go to 0: `gnt` (forced low while `RST`=1), `rvalid`, `rdata`, `mem_wren`, the memory addresses and `mem_data`.
  - `last`=B.
  - The tag pipeline is cleared, so reads in flight at reset are dropped and produce no `rvalid`.

## Timing
- Grant: 0 cycles. Combinational, in the request cycle.
- Write: `mem_wren` is high 1 cycle after acceptance.
- Read: `x_rvalid` is high 1+`RD_LAT` cycles after acceptance (2 cycles with the default).
- Throughput: 1 operation per cycle total. With both ports requesting continuously, each port gets 1 operation per 2 cycles.

## Configuration
- `LMEM_ARB_BURST_EN` defined:
  - The granted port keeps priority while its `req` stays high, for up to `MAX_BURST` consecutive accepted beats.
  - A 3-bit beat counter counts the beats. When it reaches `MAX_BURST` with the other port requesting, ownership switches.
  - The counter clears on owner change, on a cycle with no request, and on reset.
- `LMEM_ARB_BURST_EN` undefined: pure per-beat round-robin. No counter is present and `MAX_BURST` is ignored.

## Structure
- `global.h` holds `W_WIDTH`, `W_ADDR`, the port encodings `PORT_A`=0 and `PORT_B`=1, and the default `RD_LAT`.
- One sub-module: `lmem_rd_tag_pipe`. It is the parameterised {valid, port} shift register of depth 1+`RD_LAT`, with synchronous clear.
- The top instantiates `lmem_rd_tag_pipe` and `local_memory`-compatible port wiring, but does not instantiate `local_memory` itself.

## Test plan
- Reset, then A writes 0x5A to addr 3, then A reads addr 3:
  - `a_gnt` is high the same cycle as each request.
  - `mem_wren`=1 with addr 3 one cycle after the write.
  - `a_rvalid`=1 with `a_rdata`=0x5A two cycles after the read grant.
- A and B both request reads continuously:
  - Grants alternate A, B, A, B; A wins the first tie.
  - Each `rvalid` lands on the correct port with the correct data.
- B writes to addr 7 and A reads addr 7 in the same cycle:
  - B is granted first (A,B tie after `last`=A from a prior grant), then A.
  - A receives the new data.
- Assert `RST` while two reads are in flight:
  - No `rvalid` on any cycle after reset is sampled.
  - All outputs are 0 during reset.
- With `LMEM_ARB_BURST_EN` and `MAX_BURST`=4, A and B requesting continuously:
  - A is granted 4 consecutive beats, then B is granted 4.
  - A drops `req` after 2 beats: B is granted immediately and the counter clears.
- Single requester B streaming 8 reads to addrs 0–7:
  - 8 consecutive grants.
  - 8 back-to-back `b_rvalid` pulses, data in address order.
